rr_arb16: RTL and testbench

- Round-robin arbiter that lets 16 requesters share one 16:1 single-bit mux datapath.
- Drives the mux's 4-bit select and a one-hot grant vector.
- Holds a grant until the owner releases it, drops its request, or exceeds a hold limit.
- Sits between the 16 requesting channels and the mux select input. Purely sequential control; no data passes through it.

---
 rtl/rr_arb16_pkg.sv | 29 ++
 rtl/rr_pick16.sv | 44 ++++
 rtl/rr_arb16.sv | 124 ++++++++++++
 tb/tb_rr_arb16.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rr_arb16_pkg.sv
// Shared definitions for the 16-channel round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   NCH     number of requesting channels
//   SELW    width of the mux select / channel index
//   CNTW    width of the grant-hold counter
//   state_t arbiter FSM encoding
//   onehot  index -> one-hot grant helper
package rr_arb16_pkg;

    localparam int NCH  = 16;
    localparam int SELW = 4;
    localparam int CNTW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] idx);
        logic [NCH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Round-robin picker: first set request at or after ptr, wrapping mod 16.
// Latency: purely combinational.
// Backpressure: none; result valid whenever req/ptr are stable.
//
// Ports:
//   req    in   per-channel request vector
//   ptr    in   highest-priority channel index
//   found  out  1 when any request is set
//   idx    out  chosen channel index (0 when found=0)
module rr_pick16
    import rr_arb16_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [NCH-1:0]  rot;
    logic [SELW-1:0] off;

    always_comb begin
        // Rotate so that channel ptr lands at bit 0; the 4-bit index sum
        // wraps naturally, giving the mod-16 scan order for free.
        for (int i = 0; i < NCH; i++) begin
            rot[i] = req[ptr + SELW'(i)];
        end

        // Lowest set bit of the rotated vector wins; scanning downward lets
        // the last assignment be the lowest index.
        off   = '0;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = SELW'(i);
                found = 1'b1;
            end
        end

        // Un-rotate back to an absolute channel number.
        idx = found ? (ptr + off) : '0;
    end

endmodule

// File: rtl/rr_arb16.sv
// Round-robin arbiter driving a 16:1 mux select plus one-hot grant.
// Latency: 1 cycle request->grant; one dead cycle between consecutive grants.
// Backpressure: owner holds until done, request drop, or MAX_HOLD expiry.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   req      in   level request per channel
//   done     in   owner release strobe, ignored while idle
//   gnt      out  one-hot grant, zero when idle
//   sel      out  current/last owner index for the mux select
//   busy     out  high while a grant is held
//   timeout  out  one-cycle pulse when a grant was revoked by MAX_HOLD
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req,
    input  logic            done,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            timeout
);

    localparam logic [CNTW-1:0] HOLD_LIM = CNTW'(MAX_HOLD);
    localparam bit              HOLD_EN  = (MAX_HOLD != 0);

    state_t          state, state_nxt;
    logic [SELW-1:0] ptr, ptr_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [NCH-1:0]  gnt_nxt;
    logic [SELW-1:0] sel_nxt;
    logic            busy_nxt;
    logic            timeout_nxt;

    logic            pick_found;
    logic [SELW-1:0] pick_idx;

    logic            rel_done;
    logic            rel_drop;
    logic            rel_hold;
    logic            rel_any;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        gnt_nxt     = gnt;
        sel_nxt     = sel;
        busy_nxt    = busy;
        timeout_nxt = 1'b0;

        // Release causes; only meaningful while a grant is held.
        rel_done = done;
        rel_drop = ~req[sel];
        rel_hold = HOLD_EN && (cnt == HOLD_LIM);
        rel_any  = rel_done | rel_drop | rel_hold;

        case (state)
            IDLE: begin
                // sel is left untouched while nobody asks, so the mux keeps
                // pointing at the last owner.
                if (pick_found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = onehot(pick_idx);
                    sel_nxt   = pick_idx;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = CNTW'(1);
                end
            end
            GRANT: begin
                if (rel_any) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    busy_nxt    = 1'b0;
                    ptr_nxt     = sel + SELW'(1);
                    // Only a pure hold-limit expiry counts as a timeout;
                    // a cooperative release in the same cycle wins.
                    timeout_nxt = rel_hold & ~rel_done & ~rel_drop;
                end else if (cnt != {CNTW{1'b1}}) begin
                    // Saturate so an unlimited hold never wraps the counter.
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            sel     <= sel_nxt;
            busy    <= busy_nxt;
            timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arb16.sv
// Directed bench for rr_arb16 with MAX_HOLD=4.
// Each table row: inputs held for one cycle, outputs expected after the edge.
// Multi-cycle async-reset case is written out by hand after the table.
module tb_rr_arb16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    rr_arb16 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        busy;
        logic        to;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic [15:0] rq, input logic d,
                       input logic [15:0] g, input logic [3:0] s,
                       input logic b, input logic t);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d;
        v.gnt = g; v.sel = s; v.busy = b; v.to = t;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;

        //   rst req      done gnt      sel busy to
        // Single requester 5, done in its 3rd grant cycle, re-grant, drop.
        add(0, 16'h0020, 0, 16'h0020, 5, 1, 0);
        add(0, 16'h0020, 0, 16'h0020, 5, 1, 0);
        add(0, 16'h0020, 0, 16'h0020, 5, 1, 0);
        add(0, 16'h0020, 1, 16'h0000, 5, 0, 0);
        add(0, 16'h0020, 0, 16'h0020, 5, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 5, 0, 0);
        // Synchronous-looking reset, then release with no requests.
        add(1, 16'h0000, 0, 16'h0000, 0, 0, 0);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        // Round robin 0 <-> 15 with wrap, done every grant.
        add(0, 16'h8001, 0, 16'h0001, 0,  1, 0);
        add(0, 16'h8001, 1, 16'h0000, 0,  0, 0);
        add(0, 16'h8001, 0, 16'h8000, 15, 1, 0);
        add(0, 16'h8001, 1, 16'h0000, 15, 0, 0);
        add(0, 16'h8001, 0, 16'h0001, 0,  1, 0);
        add(0, 16'h8001, 1, 16'h0000, 0,  0, 0);
        add(0, 16'h8001, 0, 16'h8000, 15, 1, 0);
        add(0, 16'h8001, 1, 16'h0000, 15, 0, 0);
        // done while idle is ignored.
        add(0, 16'h0000, 1, 16'h0000, 15, 0, 0);
        // Hold limit: 4 grant cycles, timeout pulse, re-grant after one gap.
        add(0, 16'h0008, 0, 16'h0008, 3, 1, 0);
        add(0, 16'h0008, 0, 16'h0008, 3, 1, 0);
        add(0, 16'h0008, 0, 16'h0008, 3, 1, 0);
        add(0, 16'h0008, 0, 16'h0008, 3, 1, 0);
        add(0, 16'h0008, 0, 16'h0000, 3, 0, 1);
        add(0, 16'h0008, 0, 16'h0008, 3, 1, 0);
        // Same again, but done coincides with the limit: no timeout.
        add(0, 16'h0008, 0, 16'h0008, 3, 1, 0);
        add(0, 16'h0008, 0, 16'h0008, 3, 1, 0);
        add(0, 16'h0008, 0, 16'h0008, 3, 1, 0);
        add(0, 16'h0008, 1, 16'h0000, 3, 0, 0);
        // Owner 7 withdraws in its 2nd cycle; search wraps 8..15,0..2.
        add(0, 16'h0084, 0, 16'h0080, 7, 1, 0);
        add(0, 16'h0084, 0, 16'h0080, 7, 1, 0);
        add(0, 16'h0004, 0, 16'h0000, 7, 0, 0);
        add(0, 16'h0004, 0, 16'h0004, 2, 1, 0);
        add(0, 16'h0000, 0, 16'h0000, 2, 0, 0);

        // Reset state.
        @(posedge clk); #1;
        chk("reset_state", {10'd0, gnt, sel, busy, timeout}, 32'd0);

        foreach (vt[i]) begin
            rst  = vt[i].rst;
            req  = vt[i].req;
            done = vt[i].done;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i),
                {10'd0, gnt, sel, busy, timeout},
                {10'd0, vt[i].gnt, vt[i].sel, vt[i].busy, vt[i].to});
            chk($sformatf("vec%0d_inv", i),
                {31'd0, (gnt[sel] == busy) && $onehot0(gnt)}, 32'd1);
        end

        // Async reset mid-grant: ptr is 3 here, so channel 10 wins first.
        done = 1'b0;
        req  = 16'h0400;
        @(posedge clk); #1;
        chk("pre_rst_grant", {10'd0, gnt, sel, busy, timeout},
            {10'd0, 16'h0400, 4'd10, 1'b1, 1'b0});
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {10'd0, gnt, sel, busy, timeout}, 32'd0);
        req = 16'h0401;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ptr0", {10'd0, gnt, sel, busy, timeout},
            {10'd0, 16'h0001, 4'd0, 1'b1, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
